// File: rtl/lu_pkg.sv
// Shared definitions for the serial logic unit: op codes and FSM state encoding.
// Op codes are purely bitwise; no op carries between bit positions.
package lu_pkg;

   localparam logic [2:0] LU_AND    = 3'd0;
   localparam logic [2:0] LU_OR     = 3'd1;
   localparam logic [2:0] LU_XOR    = 3'd2;
   localparam logic [2:0] LU_NOR    = 3'd3;
   localparam logic [2:0] LU_NAND   = 3'd4;
   localparam logic [2:0] LU_XNOR   = 3'd5;
   localparam logic [2:0] LU_ANDN   = 3'd6;
   localparam logic [2:0] LU_PASS_A = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } lu_state_t;

endpackage

// File: rtl/lu_slice.sv
// Combinational slice of the logic unit: applies one bitwise op to SLICE bits.
// The top level reuses this single instance across cycles for every slice.
module lu_slice
   import lu_pkg::*;
#(
   parameter int SLICE = 4
) (
   input  logic [2:0]       op,
   input  logic [SLICE-1:0] a_slice,
   input  logic [SLICE-1:0] b_slice,
   output logic [SLICE-1:0] y_slice
);

   always_comb begin
      y_slice = '0;
      case (op)
         LU_AND:    y_slice = a_slice & b_slice;
         LU_OR:     y_slice = a_slice | b_slice;
         LU_XOR:    y_slice = a_slice ^ b_slice;
         LU_NOR:    y_slice = ~(a_slice | b_slice);
         LU_NAND:   y_slice = ~(a_slice & b_slice);
         LU_XNOR:   y_slice = ~(a_slice ^ b_slice);
         LU_ANDN:   y_slice = a_slice & ~b_slice;
         LU_PASS_A: y_slice = a_slice;
         default:   y_slice = '0;
      endcase
   end

endmodule

// File: rtl/lu_serial_param.sv
// Multi-cycle parametrised logic unit: computes SLICE bits per cycle into a shadow
// register and publishes result/zero/parity only when every slice is complete.
module lu_serial_param
   import lu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             parity
);

   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   lu_state_t        state_q;
   logic [CW-1:0]    cnt_q;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] shadow_q;
   logic [WIDTH-1:0] shadow_d;
   logic [WIDTH-1:0] result_q;
   logic             zero_q;
   logic             parity_q;
   logic             busy_q;
   logic             done_q;
   logic [SLICE-1:0] ySlice;
   logic             lastSlice;

   lu_slice #(.SLICE(SLICE)) u_slice (
      .op      (op_q),
      .a_slice (a_q[int'(cnt_q)*SLICE +: SLICE]),
      .b_slice (b_q[int'(cnt_q)*SLICE +: SLICE]),
      .y_slice (ySlice)
   );

   // The shadow with the current slice merged in, so the final slice can be published directly
   always_comb begin
      shadow_d = shadow_q;
      shadow_d[int'(cnt_q)*SLICE +: SLICE] = ySlice;
   end

   assign lastSlice = (cnt_q == CW'(N - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         shadow_q <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         parity_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  op_q    <= op;
                  a_q     <= a;
                  b_q     <= b;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= BUSY;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            BUSY: begin
               shadow_q <= shadow_d;
               if (lastSlice) begin
                  cnt_q    <= '0;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  result_q <= shadow_d;
                  zero_q   <= (shadow_d == '0);
                  parity_q <= ^shadow_d;
                  state_q  <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign zero   = zero_q;
   assign parity = parity_q;

endmodule

// File: tb/tb_lu_serial_param.sv
// Self-checking bench for lu_serial_param: directed cases plus random ops checked
// against a whole-word reference model; a second 8/8 instance covers SLICE == WIDTH.
module tb_lu_serial_param;

   localparam int WIDTH = 16;
   localparam int SLICE = 4;
   localparam int N     = WIDTH / SLICE;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             parity;

   logic       start2;
   logic [2:0] op2;
   logic [7:0] a2;
   logic [7:0] b2;
   logic       busy2;
   logic       done2;
   logic [7:0] result2;
   logic       zero2;
   logic       parity2;

   int checkCount = 0;
   int passCount  = 0;

   always #5 clk = ~clk;

   lu_serial_param #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .zero(zero), .parity(parity)
   );

   lu_serial_param #(.WIDTH(8), .SLICE(8)) dutWide (
      .clk(clk), .rst(rst), .start(start2), .op(op2), .a(a2), .b(b2),
      .busy(busy2), .done(done2), .result(result2), .zero(zero2), .parity(parity2)
   );

   // Whole-word reference for each op code
   function automatic logic [WIDTH-1:0] refLogic(input int opCode, input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
      case (opCode)
         0:       return x & y;
         1:       return x | y;
         2:       return x ^ y;
         3:       return ~(x | y);
         4:       return ~(x & y);
         5:       return ~(x ^ y);
         6:       return x & ~y;
         default: return x;
      endcase
   endfunction

   function automatic logic refParity(input logic [WIDTH-1:0] v);
      int ones = 0;
      for (int i = 0; i < WIDTH; i++) ones += int'(v[i]);
      return logic'(ones % 2);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // One full operation with cycle-accurate busy/done checks; optionally disturbs inputs mid-op
   task automatic applyStimulus(input logic [2:0] opIn, input logic [WIDTH-1:0] aIn,
                                input logic [WIDTH-1:0] bIn, input bit disturb);
      logic [WIDTH-1:0] expRes;
      expRes = refLogic(int'(opIn), aIn, bIn);
      op = opIn; a = aIn; b = bIn; start = 1'b1;
      stepCycle();
      start = 1'b0;
      for (int i = 1; i <= N; i++) begin
         checkOutput("busy_during_op", busy, 1);
         checkOutput("no_early_done", done, 0);
         if (disturb && i == 2) begin
            start = 1'b1; a = ~aIn; b = ~bIn; op = opIn + 3'd1;
         end else if (disturb && i == 3) begin
            start = 1'b0;
         end
         stepCycle();
      end
      checkOutput("done_pulse", done, 1);
      checkOutput("busy_low_at_done", busy, 0);
      checkOutput("result", result, 32'(expRes));
      checkOutput("zero", zero, 32'(expRes == '0));
      checkOutput("parity", parity, 32'(refParity(expRes)));
      stepCycle();
      checkOutput("done_one_cycle", done, 0);
      checkOutput("result_held", result, 32'(expRes));
   endtask

   initial begin
      logic [2:0]       rOp;
      logic [WIDTH-1:0] rA;
      logic [WIDTH-1:0] rB;
      logic [WIDTH-1:0] expSecond;
      int               doneSeen;

      rst = 1'b1; start = 1'b1; op = '0; a = '0; b = '0;
      start2 = 1'b0; op2 = '0; a2 = '0; b2 = '0;
      stepCycle();
      stepCycle();
      checkOutput("rst_beats_start_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_result", result, 0);
      checkOutput("reset_zero", zero, 0);
      checkOutput("reset_parity", parity, 0);
      rst = 1'b0; start = 1'b0;
      stepCycle();
      checkOutput("idle_busy", busy, 0);

      applyStimulus(3'd2, 16'hF0F0, 16'hFF00, 1'b0);
      applyStimulus(3'd0, 16'h0F0F, 16'hF0F0, 1'b0);
      applyStimulus(3'd4, 16'h0F0F, 16'hF0F0, 1'b0);
      for (int k = 0; k < 8; k++) applyStimulus(3'(k), 16'h1234, 16'h00FF, 1'b0);

      // start and operand changes while busy must be ignored
      applyStimulus(3'd1, 16'hA5A5, 16'h0101, 1'b1);

      // back-to-back: start held during the done cycle launches the next op
      op = 3'd2; a = 16'h1111; b = 16'h2222; start = 1'b1;
      stepCycle();
      start = 1'b0;
      for (int i = 1; i <= N; i++) stepCycle();
      checkOutput("b2b_first_done", done, 1);
      checkOutput("b2b_first_result", result, 32'h3333);
      op = 3'd6; a = 16'hFFFF; b = 16'h00F0; start = 1'b1;
      expSecond = refLogic(6, 16'hFFFF, 16'h00F0);
      stepCycle();
      start = 1'b0;
      checkOutput("b2b_busy_rises", busy, 1);
      for (int i = 1; i <= N; i++) stepCycle();
      checkOutput("b2b_second_done", done, 1);
      checkOutput("b2b_second_result", result, 32'(expSecond));
      stepCycle();

      // reset mid-operation aborts and clears the last result
      op = 3'd1; a = 16'hFFFF; b = 16'h0000; start = 1'b1;
      stepCycle();
      start = 1'b0;
      stepCycle();
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_result", result, 0);
      checkOutput("abort_parity", parity, 0);
      doneSeen = 0;
      for (int i = 0; i < 10; i++) begin
         if (done) doneSeen++;
         stepCycle();
      end
      checkOutput("abort_no_done", 32'(doneSeen), 0);

      for (int k = 0; k < 30; k++) begin
         rOp = 3'($urandom_range(0, 7));
         rA  = 16'($urandom);
         rB  = 16'($urandom);
         if (k % 7 == 0) rB = rA;
         applyStimulus(rOp, rA, rB, 1'b0);
      end

      // SLICE == WIDTH: single busy cycle, done two cycles after start
      op2 = 3'd1; a2 = 8'h81; b2 = 8'h01; start2 = 1'b1;
      stepCycle();
      start2 = 1'b0;
      checkOutput("wide_busy", busy2, 1);
      checkOutput("wide_no_early_done", done2, 0);
      stepCycle();
      checkOutput("wide_done", done2, 1);
      checkOutput("wide_busy_low", busy2, 0);
      checkOutput("wide_result", result2, 32'h81);
      checkOutput("wide_parity", parity2, 0);
      checkOutput("wide_zero", zero2, 0);
      stepCycle();
      checkOutput("wide_done_one_cycle", done2, 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
